mnist_nn_nios2_gen2_0_cpu_debug_ocimem_arbiter: RTL and testbench
=================================================================

Name: mnist_nn_nios2_gen2_0_cpu_debug_ocimem_arbiter

Overview:
- Shares the single-port on-chip debug RAM (OCI memory) between two requesters:
  - the sysclk-domain JTAG debug command path (decoded take_action/jdo commands, presented as a valid/ready command stream);
  - the CPU's Avalon debug-memory slave port.
- Sequences RAM read/write timing, keeps the JTAG auto-incrementing address pointer, and returns read data to the monitor data register (MonDReg) or to Avalon readdata.
- Round-robin arbitration.

Parameters:
- ADDR_W, 8, OCI RAM word-address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- jtag_cmd_valid  in  1  JTAG command present.
- jtag_cmd_ready  out  1  command accepted when valid&ready.
- jtag_cmd_op  in  2  encoding:
  - 00 = set address;
  - 01 = write then increment;
  - 10 = read then increment;
  - 11 = reserved.
- jtag_cmd_data  in  DATA_W  write data, or address in [ADDR_W-1:0] for op 00.
- mon_dreg  out  DATA_W  last JTAG read data.
- mon_ready  out  1  last JTAG command complete.
- mon_error  out  1  last JTAG command was reserved op.
- cpu_address  in  ADDR_W  Avalon word address.
- cpu_read  in  1  Avalon read request.
- cpu_write  in  1  Avalon write request.
- cpu_writedata  in  DATA_W  Avalon write data.
- cpu_byteenable  in  DATA_W/8  Avalon byte enables.
- cpu_readdata  out  DATA_W  Avalon read data.
- cpu_waitrequest  out  1  Avalon stall.
- ram_addr  out  ADDR_W  RAM address (registered).
- ram_wdata  out  DATA_W  RAM write data (registered).
- ram_byteenable  out  DATA_W/8  RAM byte enables (registered).
- ram_we  out  1  RAM write strobe (registered).
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after ram_addr.

Behaviour:
- Reset values: all outputs 0, except cpu_waitrequest, which follows its combinational equation; FSM = IDLE; JTAG address pointer = 0; rr pointer favours CPU.
- FSM states:
  - IDLE: arbitrate.
  - ACCESS: RAM address/strobe driven.
  - RD_CAP: capture ram_rdata.
  - DONE: one-cycle completion/handoff.
- Arbitration happens only in IDLE. Requests:
  - CPU request = cpu_read|cpu_write;
  - JTAG request = jtag_cmd_valid.
  - If both request, grant goes to the requester not granted last; the rr pointer updates on each grant.
  - If only one requests, it is granted regardless of the pointer.
- jtag_cmd_ready = 1 only in the IDLE cycle where JTAG is granted; the command is captured that cycle (cycle N).
- JTAG op 00:
  - ptr <= data[ADDR_W-1:0] at N+1;
  - no RAM access; FSM goes to DONE;
  - mon_ready=1, mon_error=0 at N+1.
- JTAG op 01:
  - ram_addr=ptr, ram_wdata=data, byteenable all-ones, ram_we=1 during N+1 (ACCESS);
  - ptr increments at N+2;
  - mon_ready=1 from N+2.
- JTAG op 10:
  - ram_addr=ptr at N+1;
  - RD_CAP at N+2: mon_dreg <= ram_rdata, ptr increments;
  - mon_ready=1 from N+3.
- JTAG op 11:
  - no RAM access; mon_error=1 and mon_ready=1 at N+1;
  - ptr unchanged.
- Accepting any JTAG command clears mon_ready (and mon_error for valid ops) at N+1, unless the command completes at N+1. mon_ready/mon_error otherwise hold until the next JTAG command.
- Pointer wraps from 2^ADDR_W-1 to 0.
- CPU grant in IDLE at cycle N; address, writedata and byteenable are latched:
  - Write: ram_we=1 during N+1; cpu_waitrequest=0 during N+1.
  - Read: ram_addr at N+1; at N+2 cpu_readdata <= ram_rdata and cpu_waitrequest=0 during N+2.
- cpu_waitrequest = (cpu_read|cpu_write) & ~cpu_done, where cpu_done is a 1-cycle completion pulse. cpu_readdata holds until the next CPU read completes.
- cpu_read and cpu_write asserted together: treated as a write.
- CPU deasserting a request mid-access: access completes, result discarded, no hang.
- ram_we is high only in ACCESS cycles for writes; otherwise 0.
- FSM always passes through DONE and returns to IDLE, so there is a minimum of 1 idle arbitration cycle between grants. Back-to-back sustained throughput: writes 1 per 3 cycles, reads 1 per 4 cycles.
- Reset mid-operation: access aborted; ram_we forced 0 the following cycle; pointer cleared; an outstanding CPU request is re-arbitrated after reset deasserts.

Test Plan:
- Reset, then JTAG op00 data=0x05; op01 data=0xDEADBEEF -> ram_we at 0x05 with 0xDEADBEEF; ptr=0x06; mon_ready=1 two cycles after accept.
- JTAG op00 data=0xFF, then op10 twice with RAM holding [0xFF]=0x11, [0x00]=0x22 -> mon_dreg=0x11, then 0x22 (wrap); mon_ready each time 3 cycles after accept.
- CPU read addr 0x10 (RAM=0xCAFEF00D) -> waitrequest high 2 cycles; readdata=0xCAFEF00D on the cycle waitrequest drops.
- CPU write and JTAG write both asserted continuously from reset -> grants alternate CPU, JTAG, CPU, JTAG; neither starves; writes land at their respective addresses.
- JTAG op11 -> mon_error=1, mon_ready=1, no ram_we, ptr unchanged; next op00 -> mon_error=0.
- Assert reset during the ACCESS cycle of a CPU read -> outputs return to reset values; after release, CPU read is re-granted and completes with correct data.

Source files
------------

// File: rtl/mnist_nn_nios2_gen2_0_cpu_debug_ocimem_arbiter_if.sv
// OCI debug RAM arbiter bus bundle: JTAG command stream, monitor
// status, CPU Avalon slave port and single-port RAM interface.
// Ports (slave = arbiter view):
//   jtag_cmd_* / mon_*   JTAG command in, monitor status out
//   cpu_*                Avalon debug-memory slave
//   ram_*                registered RAM address/data/strobe, ram_rdata in
interface mnist_nn_nios2_gen2_0_cpu_debug_ocimem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic                  jtag_cmd_valid;
    logic                  jtag_cmd_ready;
    logic [1:0]            jtag_cmd_op;
    logic [DATA_W-1:0]     jtag_cmd_data;
    logic [DATA_W-1:0]     mon_dreg;
    logic                  mon_ready;
    logic                  mon_error;
    logic [ADDR_W-1:0]     cpu_address;
    logic                  cpu_read;
    logic                  cpu_write;
    logic [DATA_W-1:0]     cpu_writedata;
    logic [DATA_W/8-1:0]   cpu_byteenable;
    logic [DATA_W-1:0]     cpu_readdata;
    logic                  cpu_waitrequest;
    logic [ADDR_W-1:0]     ram_addr;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W/8-1:0]   ram_byteenable;
    logic                  ram_we;
    logic [DATA_W-1:0]     ram_rdata;

    modport slave (
        input  jtag_cmd_valid, jtag_cmd_op, jtag_cmd_data,
        output jtag_cmd_ready, mon_dreg, mon_ready, mon_error,
        input  cpu_address, cpu_read, cpu_write,
        input  cpu_writedata, cpu_byteenable,
        output cpu_readdata, cpu_waitrequest,
        output ram_addr, ram_wdata, ram_byteenable, ram_we,
        input  ram_rdata
    );

    modport master (
        output jtag_cmd_valid, jtag_cmd_op, jtag_cmd_data,
        input  jtag_cmd_ready, mon_dreg, mon_ready, mon_error,
        output cpu_address, cpu_read, cpu_write,
        output cpu_writedata, cpu_byteenable,
        input  cpu_readdata, cpu_waitrequest,
        input  ram_addr, ram_wdata, ram_byteenable, ram_we,
        output ram_rdata
    );
endinterface

// File: rtl/mnist_nn_nios2_gen2_0_cpu_debug_ocimem_arbiter.sv
// Round-robin arbiter sharing the OCI debug RAM between the JTAG
// command stream and the CPU Avalon port; ports: clk, reset, bus.
module mnist_nn_nios2_gen2_0_cpu_debug_ocimem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input logic clk,
    input logic reset,
    mnist_nn_nios2_gen2_0_cpu_debug_ocimem_arbiter_if.slave bus
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ACCESS, RD_CAP, DONE} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_wdata_q;
    logic [BE_W-1:0]     ram_be_q;
    logic                ram_we_q;
    logic [DATA_W-1:0]   mon_dreg_q;
    logic                mon_ready_q;
    logic                mon_error_q;
    logic [DATA_W-1:0]   cpu_rdata_q;
    logic                last_cpu;
    logic                own_cpu;
    logic                own_wr;

    logic cpu_req;
    logic cpu_gnt;
    logic jtag_gnt;
    logic cpu_done;

    assign cpu_req = bus.cpu_read | bus.cpu_write;

    // CPU wins when alone or when JTAG held the last grant.
    assign cpu_gnt  = (state == IDLE) & cpu_req
                    & (~bus.jtag_cmd_valid | ~last_cpu);
    assign jtag_gnt = (state == IDLE) & bus.jtag_cmd_valid & ~cpu_gnt;

    // Writes finish in ACCESS, reads in RD_CAP.
    assign cpu_done = own_cpu
                    & (((state == ACCESS) & own_wr) | (state == RD_CAP));

    assign bus.jtag_cmd_ready  = jtag_gnt;
    assign bus.cpu_waitrequest = cpu_req & ~cpu_done;
    // Read data is forwarded straight from the RAM in the completion cycle.
    assign bus.cpu_readdata    = (cpu_done & ~own_wr) ? bus.ram_rdata
                                                     : cpu_rdata_q;
    assign bus.mon_dreg        = mon_dreg_q;
    assign bus.mon_ready       = mon_ready_q;
    assign bus.mon_error       = mon_error_q;
    assign bus.ram_addr        = ram_addr_q;
    assign bus.ram_wdata       = ram_wdata_q;
    assign bus.ram_byteenable  = ram_be_q;
    assign bus.ram_we          = ram_we_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_be_q    <= '0;
            ram_we_q    <= 1'b0;
            mon_dreg_q  <= '0;
            mon_ready_q <= 1'b0;
            mon_error_q <= 1'b0;
            cpu_rdata_q <= '0;
            last_cpu    <= 1'b0;
            own_cpu     <= 1'b0;
            own_wr      <= 1'b0;
        end else begin
            ram_we_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_gnt) begin
                        own_cpu     <= 1'b1;
                        own_wr      <= bus.cpu_write;
                        last_cpu    <= 1'b1;
                        ram_addr_q  <= bus.cpu_address;
                        ram_wdata_q <= bus.cpu_writedata;
                        ram_be_q    <= bus.cpu_byteenable;
                        ram_we_q    <= bus.cpu_write;
                        state       <= ACCESS;
                    end else if (jtag_gnt) begin
                        own_cpu  <= 1'b0;
                        last_cpu <= 1'b0;
                        unique case (bus.jtag_cmd_op)
                            2'b00: begin
                                ptr         <= bus.jtag_cmd_data[ADDR_W-1:0];
                                mon_ready_q <= 1'b1;
                                mon_error_q <= 1'b0;
                                state       <= DONE;
                            end
                            2'b01: begin
                                own_wr      <= 1'b1;
                                ram_addr_q  <= ptr;
                                ram_wdata_q <= bus.jtag_cmd_data;
                                ram_be_q    <= '1;
                                ram_we_q    <= 1'b1;
                                mon_ready_q <= 1'b0;
                                mon_error_q <= 1'b0;
                                state       <= ACCESS;
                            end
                            2'b10: begin
                                own_wr      <= 1'b0;
                                ram_addr_q  <= ptr;
                                mon_ready_q <= 1'b0;
                                mon_error_q <= 1'b0;
                                state       <= ACCESS;
                            end
                            2'b11: begin
                                mon_ready_q <= 1'b1;
                                mon_error_q <= 1'b1;
                                state       <= DONE;
                            end
                        endcase
                    end
                end
                ACCESS: begin
                    if (own_wr) begin
                        if (!own_cpu) begin
                            ptr         <= ptr + 1'b1;
                            mon_ready_q <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        state <= RD_CAP;
                    end
                end
                RD_CAP: begin
                    if (own_cpu) begin
                        cpu_rdata_q <= bus.ram_rdata;
                    end else begin
                        mon_dreg_q  <= bus.ram_rdata;
                        ptr         <= ptr + 1'b1;
                        mon_ready_q <= 1'b1;
                    end
                    state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mnist_nn_nios2_gen2_0_cpu_debug_ocimem_arbiter.sv
// Bench for the OCI debug RAM arbiter: RAM model, transaction-level
// reference (memory image, JTAG pointer, monitor/CPU read values).
module tb_mnist_nn_nios2_gen2_0_cpu_debug_ocimem_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mnist_nn_nios2_gen2_0_cpu_debug_ocimem_arbiter_if #(
        .ADDR_W(AW), .DATA_W(DW)
    ) bus ();

    mnist_nn_nios2_gen2_0_cpu_debug_ocimem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW)
    ) u_dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Physical RAM: byte-enabled write, 1-cycle registered read.
    logic [31:0] ram [256];
    always @(posedge clk) begin
        if (bus.ram_we) begin
            for (int b = 0; b < 4; b++)
                if (bus.ram_byteenable[b])
                    ram[bus.ram_addr][b*8 +: 8] <= bus.ram_wdata[b*8 +: 8];
        end
        bus.ram_rdata <= ram[bus.ram_addr];
    end

    // Reference model
    logic [31:0] mdl [256];
    int          mptr;
    logic [31:0] m_dreg;

    task automatic preload(input int a, input logic [31:0] v);
        ram[a] = v;
        mdl[a] = v;
    endtask

    task automatic at_cyc(input int c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cyc < c && n < 200);
    endtask

    task automatic jtag_send(input logic [1:0] op, input logic [31:0] d,
                             output int acc);
        acc = -1;
        @(posedge clk); #1;
        bus.jtag_cmd_valid = 1'b1;
        bus.jtag_cmd_op = op;
        bus.jtag_cmd_data = d;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.jtag_cmd_ready) begin
                acc = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        bus.jtag_cmd_valid = 1'b0;
        if (acc < 0) begin
            checks++; errors++;
            $display("FAIL jtag_accept_timeout op=%0d", op);
        end
    endtask

    task automatic cpu_xfer(input bit rd, input bit wr, input int a,
                            input logic [31:0] d, input logic [3:0] be,
                            output logic [31:0] rdata, output int waits);
        bit got = 0;
        waits = 0;
        rdata = '0;
        @(posedge clk); #1;
        bus.cpu_read = rd;
        bus.cpu_write = wr;
        bus.cpu_address = a[7:0];
        bus.cpu_writedata = d;
        bus.cpu_byteenable = be;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!bus.cpu_waitrequest) begin
                rdata = bus.cpu_readdata;
                got = 1;
                break;
            end
            waits++;
        end
        @(posedge clk); #1;
        bus.cpu_read = 1'b0;
        bus.cpu_write = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL cpu_xfer_timeout addr=%0h", a);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.mon_dreg, bus.mon_ready, bus.mon_error, bus.ram_we,
             bus.ram_addr, bus.ram_wdata, bus.ram_byteenable,
             bus.cpu_readdata, bus.jtag_cmd_ready, bus.cpu_waitrequest} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got dreg=%h rdy=%b err=%b we=%b addr=%h wd=%h be=%h rd=%h req_rdy=%b wait=%b want all 0",
                     bus.mon_dreg, bus.mon_ready, bus.mon_error, bus.ram_we,
                     bus.ram_addr, bus.ram_wdata, bus.ram_byteenable,
                     bus.cpu_readdata, bus.jtag_cmd_ready, bus.cpu_waitrequest);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        mptr = 0;
        m_dreg = '0;
    endtask

    task automatic test_jtag_write;
        int acc;
        preload(6, 32'h6666_6666);
        jtag_send(2'b00, 32'h05, acc);
        mptr = 5;
        at_cyc(acc + 1);
        checks++;
        if (bus.mon_ready !== 1'b1 || bus.mon_error !== 1'b0) begin
            errors++;
            $display("FAIL setaddr_status got rdy=%b err=%b want 1 0",
                     bus.mon_ready, bus.mon_error);
        end
        jtag_send(2'b01, 32'hDEAD_BEEF, acc);
        mdl[mptr] = 32'hDEAD_BEEF;
        mptr = (mptr + 1) % 256;
        at_cyc(acc + 1);
        checks++;
        if (bus.ram_we !== 1'b1 || bus.ram_addr !== 8'h05 ||
            bus.ram_wdata !== 32'hDEAD_BEEF || bus.ram_byteenable !== 4'hF ||
            bus.mon_ready !== 1'b0) begin
            errors++;
            $display("FAIL jtag_write_access got we=%b addr=%h wd=%h be=%h rdy=%b want 1 05 deadbeef f 0",
                     bus.ram_we, bus.ram_addr, bus.ram_wdata,
                     bus.ram_byteenable, bus.mon_ready);
        end
        at_cyc(acc + 2);
        checks++;
        if (bus.mon_ready !== 1'b1 || bus.ram_we !== 1'b0) begin
            errors++;
            $display("FAIL jtag_write_done got rdy=%b we=%b want 1 0",
                     bus.mon_ready, bus.ram_we);
        end
        jtag_send(2'b10, 32'h0, acc);
        m_dreg = mdl[mptr];
        mptr = (mptr + 1) % 256;
        at_cyc(acc + 3);
        checks++;
        if (bus.mon_dreg !== m_dreg || ram[5] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL jtag_ptr_incr got dreg=%h ram5=%h want %h deadbeef",
                     bus.mon_dreg, ram[5], m_dreg);
        end
    endtask

    task automatic test_jtag_read_wrap;
        int acc;
        logic [31:0] want [2];
        want[0] = 32'h11;
        want[1] = 32'h22;
        preload(255, 32'h11);
        preload(0, 32'h22);
        jtag_send(2'b00, 32'hFF, acc);
        mptr = 255;
        for (int i = 0; i < 2; i++) begin
            jtag_send(2'b10, 32'h0, acc);
            m_dreg = mdl[mptr];
            mptr = (mptr + 1) % 256;
            at_cyc(acc + 2);
            checks++;
            if (bus.mon_ready !== 1'b0) begin
                errors++;
                $display("FAIL jtag_read_busy%0d got rdy=%b want 0",
                         i, bus.mon_ready);
            end
            at_cyc(acc + 3);
            checks++;
            if (bus.mon_ready !== 1'b1 || bus.mon_dreg !== want[i]) begin
                errors++;
                $display("FAIL jtag_read_wrap%0d got rdy=%b dreg=%h want 1 %h",
                         i, bus.mon_ready, bus.mon_dreg, want[i]);
            end
        end
    endtask

    task automatic test_cpu_read;
        logic [31:0] rd;
        int w;
        preload(8'h10, 32'hCAFE_F00D);
        cpu_xfer(1, 0, 8'h10, 32'h0, 4'hF, rd, w);
        checks++;
        if (w !== 2 || rd !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL cpu_read got waits=%0d data=%h want 2 cafef00d",
                     w, rd);
        end
    endtask

    task automatic test_arbitration;
        logic [7:0]  qa [$];
        logic [31:0] qd [$];
        logic [7:0]  ea [6];
        logic [31:0] ed [6];
        int ci = 0;
        int ji = 0;
        bit cf, jf;
        @(posedge clk); #1;
        reset = 1'b1;
        bus.cpu_write = 1'b1;
        bus.cpu_address = 8'h40;
        bus.cpu_writedata = 32'hC000_0000;
        bus.cpu_byteenable = 4'hF;
        bus.jtag_cmd_valid = 1'b1;
        bus.jtag_cmd_op = 2'b01;
        bus.jtag_cmd_data = 32'hA000_0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        mptr = 0;
        m_dreg = '0;
        for (int n = 0; n < 60 && qa.size() < 6; n++) begin
            @(negedge clk);
            if (bus.ram_we) begin
                qa.push_back(bus.ram_addr);
                qd.push_back(bus.ram_wdata);
            end
            cf = bus.cpu_write & ~bus.cpu_waitrequest;
            jf = bus.jtag_cmd_ready;
            @(posedge clk); #1;
            if (cf) begin
                ci++;
                bus.cpu_address = 8'(8'h40 + ci);
                bus.cpu_writedata = 32'hC000_0000 + ci;
            end
            if (jf) begin
                ji++;
                bus.jtag_cmd_data = 32'hA000_0000 + ji;
            end
        end
        bus.cpu_write = 1'b0;
        bus.jtag_cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ea[2*i]   = 8'(8'h40 + i);
            ed[2*i]   = 32'hC000_0000 + i;
            ea[2*i+1] = 8'(mptr);
            ed[2*i+1] = 32'hA000_0000 + i;
            mdl[ea[2*i]] = ed[2*i];
            mdl[ea[2*i+1]] = ed[2*i+1];
            mptr = (mptr + 1) % 256;
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= qa.size()) begin
                errors++;
                $display("FAIL arb_grant%0d missing write", i);
            end else if (qa[i] !== ea[i] || qd[i] !== ed[i]) begin
                errors++;
                $display("FAIL arb_grant%0d got addr=%h data=%h want %h %h",
                         i, qa[i], qd[i], ea[i], ed[i]);
            end
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reserved;
        int acc;
        bit saw_we = 0;
        jtag_send(2'b11, 32'h0000_0077, acc);
        at_cyc(acc + 1);
        checks++;
        if (bus.mon_error !== 1'b1 || bus.mon_ready !== 1'b1) begin
            errors++;
            $display("FAIL reserved_status got err=%b rdy=%b want 1 1",
                     bus.mon_error, bus.mon_ready);
        end
        for (int i = 0; i < 3; i++) begin
            if (bus.ram_we) saw_we = 1;
            @(negedge clk);
        end
        checks++;
        if (saw_we) begin
            errors++;
            $display("FAIL reserved_no_we got ram_we pulse want none");
        end
        jtag_send(2'b10, 32'h0, acc);
        m_dreg = mdl[mptr];
        mptr = (mptr + 1) % 256;
        at_cyc(acc + 3);
        checks++;
        if (bus.mon_dreg !== m_dreg || bus.mon_error !== 1'b0) begin
            errors++;
            $display("FAIL reserved_ptr_kept got dreg=%h err=%b want %h 0",
                     bus.mon_dreg, bus.mon_error, m_dreg);
        end
        jtag_send(2'b11, 32'h0, acc);
        jtag_send(2'b00, 32'h30, acc);
        mptr = 8'h30;
        at_cyc(acc + 1);
        checks++;
        if (bus.mon_error !== 1'b0 || bus.mon_ready !== 1'b1) begin
            errors++;
            $display("FAIL reserved_clear got err=%b rdy=%b want 0 1",
                     bus.mon_error, bus.mon_ready);
        end
    endtask

    task automatic test_reset_mid;
        int acc;
        bit got = 0;
        logic [31:0] rd = '0;
        repeat (4) @(posedge clk);
        preload(8'h20, 32'h5A5A_1234);
        @(posedge clk); #1;
        bus.cpu_read = 1'b1;
        bus.cpu_address = 8'h20;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ram_addr !== 8'h20) begin
            errors++;
            $display("FAIL mid_reset_access got addr=%h want 20", bus.ram_addr);
        end
        @(negedge clk);
        checks++;
        if ({bus.mon_dreg, bus.mon_ready, bus.mon_error, bus.ram_we,
             bus.ram_addr, bus.ram_wdata, bus.ram_byteenable,
             bus.cpu_readdata} !== '0 || bus.cpu_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_values got we=%b addr=%h rd=%h rdy=%b wait=%b want 0 0 0 0 1",
                     bus.ram_we, bus.ram_addr, bus.cpu_readdata,
                     bus.mon_ready, bus.cpu_waitrequest);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        mptr = 0;
        m_dreg = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!bus.cpu_waitrequest) begin
                rd = bus.cpu_readdata;
                got = 1;
                break;
            end
        end
        @(posedge clk); #1;
        bus.cpu_read = 1'b0;
        checks++;
        if (!got || rd !== 32'h5A5A_1234) begin
            errors++;
            $display("FAIL mid_reset_regrant got done=%b data=%h want 1 5a5a1234",
                     got, rd);
        end
        jtag_send(2'b10, 32'h0, acc);
        m_dreg = mdl[0];
        mptr = 1;
        at_cyc(acc + 3);
        checks++;
        if (bus.mon_dreg !== m_dreg) begin
            errors++;
            $display("FAIL mid_reset_ptr got dreg=%h want %h",
                     bus.mon_dreg, m_dreg);
        end
    endtask

    task automatic test_random;
        int acc, w, a, bad;
        logic [1:0] op;
        logic [31:0] d, rd;
        logic [3:0] be;
        bit wr, both;
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 9) < 5) begin
                op = 2'($urandom_range(0, 3));
                d = $urandom;
                jtag_send(op, d, acc);
                if (acc < 0) continue;
                case (op)
                    2'b00: mptr = d % 256;
                    2'b01: begin
                        mdl[mptr] = d;
                        mptr = (mptr + 1) % 256;
                    end
                    2'b10: begin
                        m_dreg = mdl[mptr];
                        mptr = (mptr + 1) % 256;
                    end
                    default: ;
                endcase
                at_cyc(acc + 3);
                checks++;
                if (bus.mon_ready !== 1'b1 ||
                    bus.mon_error !== (op == 2'b11) ||
                    bus.mon_dreg !== m_dreg) begin
                    errors++;
                    $display("FAIL rand_jtag%0d op=%0d got rdy=%b err=%b dreg=%h want 1 %b %h",
                             it, op, bus.mon_ready, bus.mon_error,
                             bus.mon_dreg, (op == 2'b11), m_dreg);
                end
            end else begin
                wr = 1'($urandom_range(0, 1));
                both = wr && ($urandom_range(0, 3) == 0);
                a = $urandom_range(0, 255);
                d = $urandom;
                be = 4'($urandom_range(0, 15));
                cpu_xfer(!wr || both, wr, a, d, be, rd, w);
                checks++;
                if (wr) begin
                    mdl[a] = merge(mdl[a], d, be);
                    if (w !== 1) begin
                        errors++;
                        $display("FAIL rand_cpu_wr%0d got waits=%0d want 1",
                                 it, w);
                    end
                end else if (w !== 2 || rd !== mdl[a]) begin
                    errors++;
                    $display("FAIL rand_cpu_rd%0d addr=%h got waits=%0d data=%h want 2 %h",
                             it, a, w, rd, mdl[a]);
                end
            end
        end
        repeat (3) @(posedge clk);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (ram[i] !== mdl[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ram_image got %0d differing words want 0", bad);
        end
    endtask

    initial begin
        bus.jtag_cmd_valid = 1'b0;
        bus.jtag_cmd_op = 2'b00;
        bus.jtag_cmd_data = '0;
        bus.cpu_address = '0;
        bus.cpu_read = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_writedata = '0;
        bus.cpu_byteenable = '0;
        for (int i = 0; i < 256; i++) preload(i, $urandom);
        mptr = 0;
        m_dreg = '0;
        test_reset;
        test_jtag_write;
        test_jtag_read_wrap;
        test_cpu_read;
        test_arbitration;
        test_reserved;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
